// File: rtl/psc_trigger_pkg.sv
// ---------------------------------------------------------------------------
// psc_trigger_pkg
// Shared types and constants for the PSC trigger-link frame sequencer.
//   state_t            sequencer states (IDLE / SEND / GAP)
//   SOP, EOP           control symbols that open and close every frame
//   DEFAULT_FRAME_LEN  symbols per frame, SOP and EOP included
// ---------------------------------------------------------------------------
package psc_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SOP = 8'h3C;
  localparam logic [7:0] EOP = 8'hBC;

  localparam int DEFAULT_FRAME_LEN = 10;

endpackage

// File: rtl/psc_crc8.sv
// ---------------------------------------------------------------------------
// psc_crc8
// Byte-wide CRC-8 accumulator (polynomial 0x07, init 0x00, MSB first).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        restart the CRC at 0x00 (wins over enable)
//   enable       fold data into the CRC this cycle
//   data  [7:0]  byte to accumulate
//   crc   [7:0]  registered CRC of all bytes folded since the last clear
// ---------------------------------------------------------------------------
module psc_crc8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  localparam logic [7:0] POLY = 8'h07;

  // One byte through the bit-serial LFSR, unrolled.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] byte_in);
    logic [7:0] c;
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (enable) begin
      crc <= crc8_step(crc, data);
    end
  end

endmodule

// File: rtl/psc_trigger_frame_sequencer.sv
// ---------------------------------------------------------------------------
// psc_trigger_frame_sequencer
// Walks the FRAME_LEN-symbol frame ROM (SOP, payload, EOP) onto the link
// serializer over a valid/ready stream. Trigger requests win over periodic
// heartbeat frames; triggers arriving mid-frame are held as one pending
// request, and a further one while pending is coalesced and flagged.
// Optional build macro PSC_TRIG_CRC_EN: the symbol at address FRAME_LEN-2 is
// replaced by a CRC-8 over the payload at addresses 1..FRAME_LEN-3.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   trigger_in             trigger request, one per high cycle
//   rom_address [3:0]      registered ROM address
//   rom_is_trigger         registered payload select (1 trigger, 0 heartbeat)
//   rom_data [7:0]         combinational ROM symbol
//   tx_data [7:0], tx_k    symbol and control flag to serializer
//   tx_valid, tx_ready     stream handshake
//   busy                   high while in SEND or GAP
//   frame_done             pulse on the cycle after the EOP handshake
//   trigger_overrun        pulse when a trigger arrives while one is pending
// ---------------------------------------------------------------------------
module psc_trigger_frame_sequencer
  import psc_trigger_pkg::*;
#(
  parameter int FRAME_LEN        = DEFAULT_FRAME_LEN,
  parameter int HEARTBEAT_PERIOD = 1000,
  parameter int IFG_CYCLES       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger_in,
  output logic [3:0] rom_address,
  output logic       rom_is_trigger,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       tx_k,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       trigger_overrun
);

  if (FRAME_LEN < 2 || FRAME_LEN > 16) begin : g_bad_frame_len
    $error("psc_trigger_frame_sequencer: FRAME_LEN must be in 2..16");
  end
  if (HEARTBEAT_PERIOD < 1) begin : g_bad_heartbeat
    $error("psc_trigger_frame_sequencer: HEARTBEAT_PERIOD must be >= 1");
  end

  localparam int HB_W  = (HEARTBEAT_PERIOD > 1) ? $clog2(HEARTBEAT_PERIOD) : 1;
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [3:0]       LAST_ADDR = 4'(FRAME_LEN - 1);
  localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HEARTBEAT_PERIOD - 1);
  // Unused when IFG_CYCLES is 0: GAP is then unreachable.
  localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'(IFG_CYCLES - 1);

  state_t           state, state_nxt;
  logic [HB_W-1:0]  hb_cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic             pending;

  logic handshake, eop_hs;
  logic start_trig, start_hb, frame_start;
  logic [7:0] symbol;

  assign handshake   = (state == SEND) && tx_ready;
  assign eop_hs      = handshake && (rom_address == LAST_ADDR);
  assign start_trig  = (state == IDLE) && (trigger_in || pending);
  assign start_hb    = (state == IDLE) && !start_trig && (hb_cnt == HB_LAST);
  assign frame_start = start_trig || start_hb;

  // NOTE: every signal an always_comb writes gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = SEND;
      SEND:    if (eop_hs) state_nxt = (IFG_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (ifg_cnt == IFG_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rom_address     <= 4'd0;
      rom_is_trigger  <= 1'b0;
      pending         <= 1'b0;
      hb_cnt          <= '0;
      ifg_cnt         <= '0;
      frame_done      <= 1'b0;
      trigger_overrun <= 1'b0;
    end else begin
      state           <= state_nxt;
      frame_done      <= eop_hs;
      // A trigger on top of a pending one is merged into the same frame.
      trigger_overrun <= trigger_in && pending;

      if (state != IDLE && trigger_in) begin
        pending <= 1'b1;
      end else if (start_trig) begin
        pending <= 1'b0;
      end

      if (frame_start) begin
        hb_cnt         <= '0;
        rom_is_trigger <= start_trig;
      end else if (state == IDLE) begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end

      if (eop_hs) begin
        rom_address <= 4'd0;
      end else if (handshake) begin
        rom_address <= rom_address + 4'd1;
      end

      ifg_cnt <= (state == GAP) ? ifg_cnt + IFG_W'(1) : '0;
    end
  end

`ifdef PSC_TRIG_CRC_EN
  logic [7:0] crc;
  logic       crc_en;

  assign crc_en = handshake && (rom_address >= 4'd1) && (rom_address <= 4'(FRAME_LEN - 3));

  psc_crc8 u_crc8 (
    .clk    (clk),
    .reset  (reset),
    .clear  (frame_start),
    .enable (crc_en),
    .data   (rom_data),
    .crc    (crc)
  );

  assign symbol = (rom_address == 4'(FRAME_LEN - 2)) ? crc : rom_data;
`else
  assign symbol = rom_data;
`endif

  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);
  assign tx_data  = tx_valid ? symbol : 8'h00;
  assign tx_k     = tx_valid && ((rom_address == 4'd0) || (rom_address == LAST_ADDR));

endmodule

// File: tb/tb_psc_trigger_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_psc_trigger_frame_sequencer
// Scoreboard bench: stimulus pushes each expected frame into exp_q; the
// monitor pops and compares on every handshake, and separately checks
// stall stability and frame_done timing. Counts trigger_overrun pulses.
// ---------------------------------------------------------------------------
module tb_psc_trigger_frame_sequencer;
  import psc_trigger_pkg::*;

  localparam int FRAME_LEN = 10;
  localparam int HB_PERIOD = 1000;
  localparam int IFG       = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger_in;
  logic [3:0] rom_address;
  logic       rom_is_trigger;
  logic [7:0] rom_data;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic       trigger_overrun;

  psc_trigger_frame_sequencer #(
    .FRAME_LEN        (FRAME_LEN),
    .HEARTBEAT_PERIOD (HB_PERIOD),
    .IFG_CYCLES       (IFG)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .trigger_in      (trigger_in),
    .rom_address     (rom_address),
    .rom_is_trigger  (rom_is_trigger),
    .rom_data        (rom_data),
    .tx_data         (tx_data),
    .tx_k            (tx_k),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .frame_done      (frame_done),
    .trigger_overrun (trigger_overrun)
  );

  always #5 clk = ~clk;

  // Frame ROM: SOP, payload (0x30 at address 2 for trigger frames), EOP.
  always_comb begin
    rom_data = 8'h00;
    if (rom_address == 4'd0)                        rom_data = SOP;
    else if (rom_address == 4'(FRAME_LEN - 1))      rom_data = EOP;
    else if (rom_address == 4'd2 && rom_is_trigger) rom_data = 8'h30;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       trig;
    logic [3:0] addr;
  } sym_t;

  sym_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   overruns = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC-8 reference (poly 0x07, init 0x00, MSB first).
  function automatic logic [7:0] crc_ref(input logic [7:0] bytes [FRAME_LEN], input int first, input int last);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = first; i <= last; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ bytes[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic push_frame(input logic trig);
    logic [7:0] bytes [FRAME_LEN];
    sym_t       s;
    for (int i = 0; i < FRAME_LEN; i++) begin
      bytes[i] = (i == 0) ? 8'h3C : (i == FRAME_LEN - 1) ? 8'hBC : (i == 2 && trig) ? 8'h30 : 8'h00;
    end
`ifdef PSC_TRIG_CRC_EN
    bytes[FRAME_LEN - 2] = crc_ref(bytes, 1, FRAME_LEN - 3);
`endif
    for (int i = 0; i < FRAME_LEN; i++) begin
      s.data = bytes[i];
      s.k    = (i == 0) || (i == FRAME_LEN - 1);
      s.trig = trig;
      s.addr = 4'(i);
      exp_q.push_back(s);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_done(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (frame_done) return;
      tick();
    end
    check({name, "_timeout"}, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_address(input string name, input logic [3:0] addr, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (tx_valid && rom_address == addr) return;
      tick();
    end
    check({name, "_timeout"}, {28'd0, rom_address}, {28'd0, addr});
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, frame_done timing.
  logic prev_stall = 1'b0;
  logic prev_eop   = 1'b0;
  sym_t prev_sym;

  always @(negedge clk) begin
    sym_t e;
    if (trigger_overrun) overruns++;
    if (reset) begin
      prev_stall = 1'b0;
      prev_eop   = 1'b0;
    end else begin
      if (frame_done || prev_eop)
        check("frame_done", {31'd0, frame_done}, {31'd0, prev_eop});
      if (prev_stall)
        check("stall_hold", {18'd0, tx_valid, tx_data, tx_k, rom_address},
              {18'd0, 1'b1, prev_sym.data, prev_sym.k, prev_sym.addr});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol: got 0x%0h with no frame expected at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("symbol", {18'd0, tx_data, tx_k, rom_is_trigger, rom_address},
                {18'd0, e.data, e.k, e.trig, e.addr});
        end
      end
      prev_stall    = tx_valid && !tx_ready;
      prev_eop      = tx_valid && tx_ready && (rom_address == 4'(FRAME_LEN - 1));
      prev_sym.data = tx_data;
      prev_sym.k    = tx_k;
      prev_sym.trig = rom_is_trigger;
      prev_sym.addr = rom_address;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   ov0;
    logic was_valid;

    reset      = 1'b1;
    trigger_in = 1'b0;
    tx_ready   = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          {14'd0, tx_valid, busy, frame_done, trigger_overrun, rom_is_trigger, rom_address, tx_k, tx_data},
          32'd0);
    reset = 1'b0;

    // 1: single trigger, ready always high.
    tick();
    tick();
    trigger_in = 1'b1;
    push_frame(1'b1);
    tick();
    trigger_in = 1'b0;
    check("t1_latency", {26'd0, tx_valid, rom_is_trigger, rom_address}, {26'd0, 1'b1, 1'b1, 4'd0});
    wait_frame_done("t1_done", 40);
    check("t1_gap1", {30'd0, busy, tx_valid}, 32'b10);
    tick();
    check("t1_gap2", {30'd0, busy, tx_valid}, 32'b10);
    tick();
    check("t1_idle", {30'd0, busy, tx_valid}, 32'b00);
    check("t1_queue", exp_q.size(), 32'd0);

    // 2: heartbeat 1000 clks after reset release, then every 1012 clks.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_frame(1'b0);
    n = 0;
    while (!tx_valid && n < 1100) begin
      tick();
      n++;
    end
    check("t2_hb_first", n, 32'd1000);
    check("t2_hb_is_trigger", {31'd0, rom_is_trigger}, 32'd0);
    push_frame(1'b0);
    n         = 0;
    was_valid = 1'b1;
    while (n < 1200) begin
      tick();
      n++;
      if (tx_valid && !was_valid) break;
      was_valid = tx_valid;
    end
    check("t2_hb_period", n, 32'd1012);
    wait_frame_done("t2_done", 40);
    repeat (3) tick();
    check("t2_queue", exp_q.size(), 32'd0);

    // 3: random back-pressure.
    trigger_in = 1'b1;
    push_frame(1'b1);
    tick();
    trigger_in = 1'b0;
    n = 0;
    while (!frame_done && n < 200) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("t3_done", {31'd0, frame_done}, 32'd1);
    tx_ready = 1'b1;
    repeat (3) tick();
    check("t3_queue", exp_q.size(), 32'd0);

    // 4: triggers at symbols 3 and 5 of a trigger frame.
    ov0        = overruns;
    trigger_in = 1'b1;
    push_frame(1'b1);
    push_frame(1'b1);
    tick();
    trigger_in = 1'b0;
    wait_address("t4_addr3", 4'd3, 20);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    wait_address("t4_addr5", 4'd5, 20);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    wait_frame_done("t4_done1", 40);
    check("t4_gap1", {30'd0, busy, tx_valid}, 32'b10);
    tick();
    check("t4_gap2", {30'd0, busy, tx_valid}, 32'b10);
    tick();
    check("t4_idle", {30'd0, busy, tx_valid}, 32'b00);
    tick();
    check("t4_restart", {27'd0, tx_valid, rom_is_trigger, rom_address}, {27'd0, 1'b1, 1'b1, 4'd0});
    wait_frame_done("t4_done2", 40);
    repeat (3) tick();
    check("t4_overruns", overruns - ov0, 32'd1);
    check("t4_queue", exp_q.size(), 32'd0);

    // 5a: trigger on the heartbeat-expiry cycle, then counter restarts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (999) tick();
    trigger_in = 1'b1;
    push_frame(1'b1);
    tick();
    trigger_in = 1'b0;
    check("t5_trig_wins", {30'd0, tx_valid, rom_is_trigger}, 32'b11);
    wait_frame_done("t5_done", 40);
    push_frame(1'b0);
    n = 0;
    while (!tx_valid && n < 1100) begin
      tick();
      n++;
    end
    check("t5_hb_restart", n, 32'd1002);
    wait_frame_done("t5_hb_done", 40);
    repeat (3) tick();

    // 5b: reset mid-frame at symbol 4, then a full frame from SOP.
    trigger_in = 1'b1;
    push_frame(1'b1);
    tick();
    trigger_in = 1'b0;
    wait_address("t5_addr4", 4'd4, 20);
    reset = 1'b1;
    #1;
    check("t5_reset_outputs",
          {14'd0, tx_valid, busy, frame_done, trigger_overrun, rom_is_trigger, rom_address, tx_k, tx_data},
          32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    trigger_in = 1'b1;
    push_frame(1'b1);
    tick();
    trigger_in = 1'b0;
    check("t5_resync_sop", {19'd0, tx_valid, tx_k, tx_data, rom_address},
          {19'd0, 1'b1, 1'b1, 8'h3C, 4'd0});
    wait_frame_done("t5_resync_done", 40);
    repeat (3) tick();

    check("final_queue", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
